axi_reg_master: RTL and testbench
=================================

# axi_reg_master

Single-outstanding AXI4 initiator that converts a simple command/response handshake into one-beat register reads and writes. It sits on the master side of the peripheral crossbar and drives register accesses to PLIC, timer and other AXI slave peripherals, e.g. from a boot/debug sequencer or an FPGA test harness. Exactly one transaction is in flight at a time.

## Interface
- AXI_ADDR_WIDTH, 64, address width of command and AW/AR
- AXI_DATA_WIDTH, 64, data width; must be 32 or 64
- AXI_ID_WIDTH, 6, width of AWID/ARID/BID/RID
- AXI_USER_WIDTH, 1, width of all USER fields (driven 0)
- TXN_ID, 0, constant ID driven on AWID/ARID
- aclk in 1: sole clock; all logic on rising edge
- areset in 1: synchronous, active-high reset
- cmd_valid in 1 / cmd_ready out 1: command handshake
- cmd_write in 1: 1 = write, 0 = read
- cmd_addr in AXI_ADDR_WIDTH: byte address
- cmd_wdata in AXI_DATA_WIDTH / cmd_wstrb in AXI_DATA_WIDTH/8: write payload (ignored for reads)
- rsp_valid out 1 / rsp_ready in 1: response handshake
- rsp_rdata out AXI_DATA_WIDTH: read data (0 for writes)
- rsp_resp out 2: BRESP/RRESP of the completed transaction
- rsp_err out 1: protocol check failure (see Configuration)
- m_axi_aw* out: awid, awaddr, awlen(8), awsize(3), awburst(2), awlock, awcache(4), awprot(3), awqos(4), awregion(4), awatop(6), awuser, awvalid; awready in
- m_axi_w*: wdata, wstrb, wlast, wuser, wvalid out; wready in
- m_axi_b*: bid, bresp, buser, bvalid in; bready out
- m_axi_ar* out: same field set as AW minus atop, arvalid; arready in
- m_axi_r*: rid, rdata, rresp, rlast, ruser, rvalid in; rready out

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On cmd_valid, latch command; go to WR_REQ (write) or RD_REQ (read).
- WR_REQ: awvalid and wvalid asserted together; each drops independently after its own handshake; AW and W may complete in either order or in the same cycle. When both are done -> WR_RESP.
- WR_RESP: bready=1; on bvalid latch bresp, rsp_rdata=0 -> RSP.
- RD_REQ: arvalid=1 until arready -> RD_RESP.
- RD_RESP: rready=1; on rvalid latch rdata/rresp -> RSP.
- RSP: rsp_valid=1, held stable until rsp_ready; then -> IDLE.
- Fixed fields: len=0, size=log2(AXI_DATA_WIDTH/8), burst=INCR (01), cache=0000, prot/lock/qos/region/atop/user=0, wlast=1, id=TXN_ID.
- Address bits below size are forced to 0; wstrb passed unchanged.
- An early bvalid (before AW/W done) is not accepted: bready=0 outside WR_RESP.

## Timing
- Reset values: cmd_ready=0 during reset, 1 in the first cycle after; all *valid, bready, rready, rsp_valid, rsp_err =0; rsp_rdata, rsp_resp, AXI payloads =0.
- All AXI outputs and rsp_* registered.
- Command accepted at cycle T -> awvalid/wvalid (or arvalid) high at T+1.
- Zero-wait slave: AW/W handshake at T+1, bvalid at T+2 earliest, rsp_valid at T+3. Read: same, with rvalid.
- cmd_ready is 0 from T+1 until the cycle after the rsp handshake; minimum command period is 4 cycles.
- Valid signals never drop before their handshake; payloads stable while valid.
- Reset mid-transaction: FSM returns to IDLE and the transaction is abandoned; the interconnect and slaves share areset.

## Configuration
- AXI_REG_MASTER_RESP_CHECK_EN defined: rsp_err=1 with the response if bid/rid != TXN_ID or rlast=0 on a read beat. rsp_resp is still reported.
- Not defined: bid/rid/rlast are ignored and rsp_err is tied 0.

## Structure
- axi_reg_master_pkg: state enum, AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, the device cache constant and the size-from-width function.
- One sub-module: axi_reg_master_rsp_buf, a single-entry valid/ready holding register for rdata/resp/err.

## Test plan
- Write 0x0C00_2000 / 0xDEAD_BEEF / strb 0x0F, zero-wait slave -> one AW+W beat, awsize=3, wlast=1, rsp_valid at T+3, rsp_resp=00.
- awready held low 5 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 5 cycles, bready asserted only after both are accepted.
- Read 0x0200_BFF8 with rvalid delayed 10 cycles, rdata=0x1234, rresp=10 -> rsp_rdata=0x1234, rsp_resp=10.
- rsp_ready low 4 cycles after completion -> rsp_valid and data stable, cmd_ready stays 0, no new AR/AW is issued.
- With AXI_REG_MASTER_RESP_CHECK_EN, rid=TXN_ID+1 -> rsp_err=1; without the macro -> rsp_err=0.
- areset asserted while in RD_RESP -> next cycle all valids are 0 and cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_reg_master_pkg.sv
// Shared types and AXI constants for the single-outstanding register master.
package axi_reg_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR  = 2'b11;
  localparam logic [3:0] AXI_CACHE_DEVICE = 4'b0000;

  // AxSIZE encoding for a full-width beat of the given data width.
  function automatic int unsigned axi_size_log2(input int unsigned data_width);
    case (data_width)
      8:       return 0;
      16:      return 1;
      32:      return 2;
      64:      return 3;
      128:     return 4;
      default: return 3;
    endcase
  endfunction

endpackage

// File: rtl/axi_reg_master_if.sv
// AXI4 bus bundle between the register master and the peripheral crossbar.
interface axi_reg_master_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   awid;
  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      awlock;
  logic [3:0]                awcache;
  logic [2:0]                awprot;
  logic [3:0]                awqos;
  logic [3:0]                awregion;
  logic [5:0]                awatop;
  logic [AXI_USER_WIDTH-1:0] awuser;
  logic                      awvalid;
  logic                      awready;

  logic [AXI_DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]         wstrb;
  logic                      wlast;
  logic [AXI_USER_WIDTH-1:0] wuser;
  logic                      wvalid;
  logic                      wready;

  logic [AXI_ID_WIDTH-1:0]   bid;
  logic [1:0]                bresp;
  logic [AXI_USER_WIDTH-1:0] buser;
  logic                      bvalid;
  logic                      bready;

  logic [AXI_ID_WIDTH-1:0]   arid;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      arlock;
  logic [3:0]                arcache;
  logic [2:0]                arprot;
  logic [3:0]                arqos;
  logic [3:0]                arregion;
  logic [AXI_USER_WIDTH-1:0] aruser;
  logic                      arvalid;
  logic                      arready;

  logic [AXI_ID_WIDTH-1:0]   rid;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic [AXI_USER_WIDTH-1:0] ruser;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awatop, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awatop, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_reg_master_rsp_buf.sv
// Single-entry valid/ready holding register for the completed response.
module axi_reg_master_rsp_buf #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_resp,
  input  logic              i_err,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_rdata,
  output logic [1:0]        o_resp,
  output logic              o_err
);

  logic              r_valid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_resp;
  logic              r_err;

  // Payload only changes on load, so it stays stable while valid is held.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_resp  <= 2'b00;
      r_err   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_rdata <= i_rdata;
      r_resp  <= i_resp;
      r_err   <= i_err;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_rdata = r_rdata;
  assign o_resp  = r_resp;
  assign o_err   = r_err;

endmodule

// File: rtl/axi_reg_master.sv
// Single-outstanding AXI4 register master: one command -> one single-beat read or write.
// Optional: define AXI_REG_MASTER_RESP_CHECK_EN to flag BID/RID/RLAST protocol errors on rsp_err.
module axi_reg_master
  import axi_reg_master_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter int unsigned TXN_ID         = 0
) (
  input  logic                        i_aclk,
  input  logic                        i_areset,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                  o_rsp_resp,
  output logic                        o_rsp_err,
  axi_reg_master_if.master            m_axi
);

  localparam int unsigned STRB_W    = AXI_DATA_WIDTH / 8;
  localparam int unsigned SIZE_LOG2 = axi_size_log2(AXI_DATA_WIDTH);

  state_t r_state, w_state_next;

  logic r_cmd_ready, r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
  logic w_cmd_ready_d, w_awvalid_d, w_wvalid_d, w_arvalid_d, w_bready_d, w_rready_d;

  logic [AXI_ADDR_WIDTH-1:0] r_awaddr, r_araddr, w_addr_aligned;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]         r_wstrb;

  logic w_cmd_fire, w_aw_done, w_w_done, w_b_fire, w_r_fire, w_rsp_fire;
  logic w_b_err, w_r_err, w_unused;

  logic                      w_ld_valid;
  logic [AXI_DATA_WIDTH-1:0] w_ld_rdata;
  logic [1:0]                w_ld_resp;
  logic                      w_ld_err;

  assign w_cmd_fire     = r_cmd_ready & i_cmd_valid;
  assign w_aw_done      = ~r_awvalid | m_axi.awready;
  assign w_w_done       = ~r_wvalid | m_axi.wready;
  assign w_b_fire       = r_bready & m_axi.bvalid;
  assign w_r_fire       = r_rready & m_axi.rvalid;
  assign w_rsp_fire     = o_rsp_valid & i_rsp_ready;
  assign w_addr_aligned = {i_cmd_addr[AXI_ADDR_WIDTH-1:SIZE_LOG2], SIZE_LOG2'(0)};

`ifdef AXI_REG_MASTER_RESP_CHECK_EN
  assign w_b_err  = (m_axi.bid != AXI_ID_WIDTH'(TXN_ID));
  assign w_r_err  = (m_axi.rid != AXI_ID_WIDTH'(TXN_ID)) | ~m_axi.rlast;
  assign w_unused = ^{m_axi.buser, m_axi.ruser, i_cmd_addr[SIZE_LOG2-1:0]};
`else
  assign w_b_err  = 1'b0;
  assign w_r_err  = 1'b0;
  assign w_unused = ^{m_axi.bid, m_axi.rid, m_axi.rlast, m_axi.buser, m_axi.ruser,
                      i_cmd_addr[SIZE_LOG2-1:0]};
`endif

  always_ff @(posedge i_aclk) begin
    if (i_areset) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_cmd_fire) w_state_next = i_cmd_write ? ST_WR_REQ : ST_RD_REQ;
      ST_WR_REQ:  if (w_aw_done && w_w_done) w_state_next = ST_WR_RESP;
      ST_WR_RESP: if (w_b_fire) w_state_next = ST_RSP;
      ST_RD_REQ:  if (r_arvalid && m_axi.arready) w_state_next = ST_RD_RESP;
      ST_RD_RESP: if (w_r_fire) w_state_next = ST_RSP;
      ST_RSP:     if (w_rsp_fire) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered handshake outputs and the response-buffer load.
  always_comb begin
    w_cmd_ready_d = (w_state_next == ST_IDLE);
    w_bready_d    = (w_state_next == ST_WR_RESP);
    w_rready_d    = (w_state_next == ST_RD_RESP);
    w_awvalid_d   = 1'b0;
    w_wvalid_d    = 1'b0;
    w_arvalid_d   = 1'b0;
    w_ld_valid    = 1'b0;
    w_ld_rdata    = '0;
    w_ld_resp     = AXI_RESP_OKAY;
    w_ld_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          w_awvalid_d = i_cmd_write;
          w_wvalid_d  = i_cmd_write;
          w_arvalid_d = ~i_cmd_write;
        end
      end
      ST_WR_REQ: begin
        w_awvalid_d = r_awvalid & ~m_axi.awready;
        w_wvalid_d  = r_wvalid & ~m_axi.wready;
      end
      ST_RD_REQ: w_arvalid_d = r_arvalid & ~m_axi.arready;
      ST_WR_RESP: begin
        if (w_b_fire) begin
          w_ld_valid = 1'b1;
          w_ld_resp  = m_axi.bresp;
          w_ld_err   = w_b_err;
        end
      end
      ST_RD_RESP: begin
        if (w_r_fire) begin
          w_ld_valid = 1'b1;
          w_ld_rdata = m_axi.rdata;
          w_ld_resp  = m_axi.rresp;
          w_ld_err   = w_r_err;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_cmd_ready <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
    end else begin
      r_cmd_ready <= w_cmd_ready_d;
      r_awvalid   <= w_awvalid_d;
      r_wvalid    <= w_wvalid_d;
      r_arvalid   <= w_arvalid_d;
      r_bready    <= w_bready_d;
      r_rready    <= w_rready_d;
      if (w_cmd_fire) begin
        if (i_cmd_write) begin
          r_awaddr <= w_addr_aligned;
          r_wdata  <= i_cmd_wdata;
          r_wstrb  <= i_cmd_wstrb;
        end else begin
          r_araddr <= w_addr_aligned;
        end
      end
    end
  end

  axi_reg_master_rsp_buf #(.DATA_W(AXI_DATA_WIDTH)) u_rsp_buf (
    .i_clk   (i_aclk),
    .i_rst   (i_areset),
    .i_load  (w_ld_valid),
    .i_rdata (w_ld_rdata),
    .i_resp  (w_ld_resp),
    .i_err   (w_ld_err),
    .i_ready (i_rsp_ready),
    .o_valid (o_rsp_valid),
    .o_rdata (o_rsp_rdata),
    .o_resp  (o_rsp_resp),
    .o_err   (o_rsp_err)
  );

  assign o_cmd_ready = r_cmd_ready;

  assign m_axi.awid     = AXI_ID_WIDTH'(TXN_ID);
  assign m_axi.awaddr   = r_awaddr;
  assign m_axi.awlen    = 8'd0;
  assign m_axi.awsize   = 3'(SIZE_LOG2);
  assign m_axi.awburst  = AXI_BURST_INCR;
  assign m_axi.awlock   = 1'b0;
  assign m_axi.awcache  = AXI_CACHE_DEVICE;
  assign m_axi.awprot   = 3'b000;
  assign m_axi.awqos    = 4'd0;
  assign m_axi.awregion = 4'd0;
  assign m_axi.awatop   = 6'd0;
  assign m_axi.awuser   = '0;
  assign m_axi.awvalid  = r_awvalid;

  assign m_axi.wdata    = r_wdata;
  assign m_axi.wstrb    = r_wstrb;
  assign m_axi.wlast    = 1'b1;
  assign m_axi.wuser    = '0;
  assign m_axi.wvalid   = r_wvalid;
  assign m_axi.bready   = r_bready;

  assign m_axi.arid     = AXI_ID_WIDTH'(TXN_ID);
  assign m_axi.araddr   = r_araddr;
  assign m_axi.arlen    = 8'd0;
  assign m_axi.arsize   = 3'(SIZE_LOG2);
  assign m_axi.arburst  = AXI_BURST_INCR;
  assign m_axi.arlock   = 1'b0;
  assign m_axi.arcache  = AXI_CACHE_DEVICE;
  assign m_axi.arprot   = 3'b000;
  assign m_axi.arqos    = 4'd0;
  assign m_axi.arregion = 4'd0;
  assign m_axi.aruser   = '0;
  assign m_axi.arvalid  = r_arvalid;
  assign m_axi.rready   = r_rready;

endmodule

// File: tb/tb_axi_reg_master.sv
// Directed testbench for axi_reg_master; the bench plays the AXI slave cycle by cycle.
module tb_axi_reg_master;
  localparam int unsigned AW  = 64;
  localparam int unsigned DW  = 64;
  localparam int unsigned IW  = 6;
  localparam int unsigned UW  = 1;
  localparam int unsigned TXN = 0;
`ifdef AXI_REG_MASTER_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            areset;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wstrb;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;

  axi_reg_master_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                      .AXI_USER_WIDTH(UW)) bus ();

  axi_reg_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
                   .AXI_USER_WIDTH(UW), .TXN_ID(TXN)) dut (
    .i_aclk      (clk),
    .i_areset    (areset),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_write (cmd_write),
    .i_cmd_addr  (cmd_addr),
    .i_cmd_wdata (cmd_wdata),
    .i_cmd_wstrb (cmd_wstrb),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_resp  (rsp_resp),
    .o_rsp_err   (rsp_err),
    .m_axi       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {awvalid, wvalid, arvalid, bready, rready, rsp_valid}
  logic [5:0] vec;
  assign vec = {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [DW/8-1:0] st);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_wstrb = st;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;
    bus.awready = 1'b1; bus.wready = 1'b1; bus.arready = 1'b1;
    bus.bvalid = 1'b0; bus.bid = '0; bus.bresp = 2'b00; bus.buser = '0;
    bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = 2'b00;
    bus.rlast = 1'b1; bus.ruser = '0;
    repeat (3) tick();
    checks++;
    if (vec !== 6'b000000) begin errors++; $display("FAIL reset_valids got %b exp 000000", vec); end
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
    checks++;
    if ({rsp_rdata, rsp_resp, rsp_err} !== '0) begin
      errors++; $display("FAIL reset_rsp got %h/%b/%b exp 0", rsp_rdata, rsp_resp, rsp_err);
    end
    checks++;
    if (bus.awaddr !== '0 || bus.araddr !== '0 || bus.wdata !== '0) begin
      errors++; $display("FAIL reset_payload got aw %h ar %h wd %h exp 0", bus.awaddr, bus.araddr, bus.wdata);
    end
    areset = 1'b0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cmd_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    issue(1'b1, 64'h0C00_2000, 64'hDEAD_BEEF, 8'h0F);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready got %b exp 1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (vec !== 6'b110000) begin errors++; $display("FAIL wr_t1_valids got %b exp 110000", vec); end
    checks++;
    if (bus.awaddr !== 64'h0C00_2000 || bus.wdata !== 64'hDEAD_BEEF || bus.wstrb !== 8'h0F) begin
      errors++; $display("FAIL wr_payload got %h %h %h exp 0c002000 deadbeef 0f", bus.awaddr, bus.wdata, bus.wstrb);
    end
    checks++;
    if ({bus.awsize, bus.awlen, bus.awburst, bus.wlast, bus.awid} !== {3'd3, 8'd0, 2'b01, 1'b1, 6'd0}) begin
      errors++; $display("FAIL wr_fixed got size %0d len %0d burst %b last %b id %0d exp 3 0 01 1 0",
                         bus.awsize, bus.awlen, bus.awburst, bus.wlast, bus.awid);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_busy_cmd_ready got %b exp 0", cmd_ready); end
    tick();
    checks++;
    if (vec !== 6'b000100) begin errors++; $display("FAIL wr_t2_valids got %b exp 000100", vec); end
    bus.bvalid = 1'b1; bus.bresp = 2'b00;
    tick();
    bus.bvalid = 1'b0;
    checks++;
    if (vec !== 6'b000001) begin errors++; $display("FAIL wr_t3_valids got %b exp 000001", vec); end
    checks++;
    if (rsp_resp !== 2'b00 || rsp_rdata !== '0) begin
      errors++; $display("FAIL wr_rsp got %b/%h exp 00/0", rsp_resp, rsp_rdata);
    end
    tick();
    checks++;
    if (vec !== 6'b000000 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL wr_t4_idle got %b/%b exp 000000/1", vec, cmd_ready);
    end
  endtask

  task automatic test_aw_stall();
    bus.awready = 1'b0;
    bus.wready  = 1'b1;
    issue(1'b1, 64'h0C00_2008, 64'h1, 8'hFF);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (vec !== 6'b110000) begin errors++; $display("FAIL stall_t1 got %b exp 110000", vec); end
    tick();
    bus.bvalid = 1'b1; bus.bresp = 2'b01;
    checks++;
    if (vec !== 6'b100000) begin errors++; $display("FAIL stall_wdrop got %b exp 100000", vec); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (vec !== 6'b100000) begin errors++; $display("FAIL stall_hold%0d got %b exp 100000", i, vec); end
    end
    bus.awready = 1'b1;
    tick();
    checks++;
    if (vec !== 6'b000100) begin errors++; $display("FAIL stall_bready got %b exp 000100", vec); end
    tick();
    bus.bvalid = 1'b0;
    checks++;
    if (vec !== 6'b000001 || rsp_resp !== 2'b01) begin
      errors++; $display("FAIL stall_rsp got %b/%b exp 000001/01", vec, rsp_resp);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL stall_done got %b exp 1", cmd_ready); end
  endtask

  task automatic test_read_rsp_stall();
    issue(1'b0, 64'h0200_BFF8, '0, '0);
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (vec !== 6'b001000 || bus.araddr !== 64'h0200_BFF8 || bus.arsize !== 3'd3) begin
      errors++; $display("FAIL rd_ar got %b %h %0d exp 001000 0200bff8 3", vec, bus.araddr, bus.arsize);
    end
    tick();
    rsp_ready = 1'b0;
    repeat (9) tick();
    checks++;
    if (vec !== 6'b000010) begin errors++; $display("FAIL rd_wait got %b exp 000010", vec); end
    bus.rvalid = 1'b1; bus.rdata = 64'h1234; bus.rresp = 2'b10; bus.rlast = 1'b1; bus.rid = '0;
    tick();
    bus.rvalid = 1'b0;
    checks++;
    if (vec !== 6'b000001 || rsp_rdata !== 64'h1234 || rsp_resp !== 2'b10 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL rd_rsp got %b %h %b %b exp 000001 1234 10 0", vec, rsp_rdata, rsp_resp, rsp_err);
    end
    issue(1'b1, 64'h0C00_2005, 64'h55, 8'hF0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({vec, cmd_ready} !== 7'b0000010 || rsp_rdata !== 64'h1234 || rsp_resp !== 2'b10) begin
        errors++; $display("FAIL rsp_hold%0d got %b/%b %h %b exp 000001/0 1234 10", i, vec, cmd_ready, rsp_rdata, rsp_resp);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (vec !== 6'b000000 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_accept got %b/%b exp 000000/1", vec, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (vec !== 6'b110000 || bus.awaddr !== 64'h0C00_2000 || bus.wstrb !== 8'hF0) begin
      errors++; $display("FAIL b2b_aw got %b %h %h exp 110000 0c002000 f0", vec, bus.awaddr, bus.wstrb);
    end
    tick();
    bus.bvalid = 1'b1; bus.bresp = 2'b00;
    tick();
    bus.bvalid = 1'b0;
    checks++;
    if (vec !== 6'b000001 || rsp_rdata !== '0) begin
      errors++; $display("FAIL b2b_rsp got %b %h exp 000001 0", vec, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_resp_check();
    issue(1'b0, 64'h1000, '0, '0);
    tick();
    cmd_valid = 1'b0;
    tick();
    bus.rvalid = 1'b1; bus.rid = IW'(TXN + 1); bus.rdata = 64'hABCD; bus.rresp = 2'b00; bus.rlast = 1'b1;
    tick();
    bus.rvalid = 1'b0; bus.rid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== EXP_ERR || rsp_rdata !== 64'hABCD) begin
      errors++; $display("FAIL chk_rid got %b %b %h exp 1 %b abcd", rsp_valid, rsp_err, rsp_rdata, EXP_ERR);
    end
    tick();
    issue(1'b0, 64'h1008, '0, '0);
    tick();
    cmd_valid = 1'b0;
    tick();
    bus.rvalid = 1'b1; bus.rdata = 64'h5; bus.rresp = 2'b11; bus.rlast = 1'b0;
    tick();
    bus.rvalid = 1'b0; bus.rlast = 1'b1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== EXP_ERR || rsp_resp !== 2'b11) begin
      errors++; $display("FAIL chk_rlast got %b %b %b exp 1 %b 11", rsp_valid, rsp_err, rsp_resp, EXP_ERR);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 64'h3000, '0, '0);
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if (vec !== 6'b000010) begin errors++; $display("FAIL mid_rd_resp got %b exp 000010", vec); end
    areset = 1'b1;
    tick();
    checks++;
    if (vec !== 6'b000000 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %b/%b exp 000000/0", vec, cmd_ready);
    end
    areset = 1'b0;
    tick();
    checks++;
    if (vec !== 6'b000000 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mid_release got %b/%b exp 000000/1", vec, cmd_ready);
    end
    issue(1'b0, 64'h2000, '0, '0);
    tick();
    cmd_valid = 1'b0;
    tick();
    bus.rvalid = 1'b1; bus.rdata = 64'h77; bus.rresp = 2'b00;
    tick();
    bus.rvalid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h77) begin
      errors++; $display("FAIL mid_recover got %b %h exp 1 77", rsp_valid, rsp_rdata);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_aw_stall();
    test_read_rsp_stall();
    test_resp_check();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
